register_file: RTL and testbench

Parametrised general-purpose register file for the pipelined core, with configurable data width, register count and read-port count. It adds a synchronous reset that zero-clears the array through a sequenced clear, a `ready` flag, write-to-read bypass, and explicit out-of-range address handling. It sits between instruction decode, which supplies read addresses, and writeback, which supplies the write address and data. The pipeline's `clk_enable` stalls it.

---
 rtl/register_file_if.sv | 23 ++
 rtl/register_file.sv | 108 ++++++++++
 tb/tb_register_file.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file bus: writeback request, decode read addresses, registered read data and ready.
interface register_file_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic                       clk_enable;
  logic                       write_enable;
  logic [ADDR_W-1:0]          write_addr;
  logic [XLEN-1:0]            write_data;
  logic [NUM_READ*ADDR_W-1:0] read_addr;
  logic [NUM_READ*XLEN-1:0]   read_data;
  logic                       ready;

  modport master (
    output clk_enable, write_enable, write_addr, write_data, read_addr,
    input  read_data, ready
  );
  modport slave (
    input  clk_enable, write_enable, write_addr, write_data, read_addr,
    output read_data, ready
  );
endinterface

// File: rtl/register_file.sv
// General-purpose register file: sequenced clear after reset, NUM_READ registered
// read ports with write bypass, r0 hardwired to zero, out-of-range addresses read as zero.
module register_file_lane #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               run_en,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               wr_ok,
  input  logic [ADDR_W-1:0]                  write_addr,
  input  logic [XLEN-1:0]                    write_data,
  input  logic [NUM_REGS-1:0][XLEN-1:0]      mem_view,
  output logic [XLEN-1:0]                    rdata
);
  logic [XLEN-1:0] nxt;

  // Exact-match decode: an address >= NUM_REGS matches nothing and reads 0
  always_comb begin
    nxt = '0;
    for (int r = 1; r < NUM_REGS; r++)
      if (addr == ADDR_W'(r)) nxt = mem_view[r];
    if (wr_ok && write_addr == addr) nxt = write_data;
  end

  always_ff @(posedge clk) begin
    if (rst)         rdata <= '0;
    else if (run_en) rdata <= nxt;
  end
endmodule

module register_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);
  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t                             state;
  logic [ADDR_W-1:0]                  idx;
  logic                               ready_q;
  logic [NUM_REGS-1:1][XLEN-1:0]      mem;
  logic [NUM_REGS-1:0][XLEN-1:0]      mem_view;
  logic [NUM_READ-1:0][XLEN-1:0]      rd_lane;
  logic                               run_en;
  logic                               wr_ok;

  assign mem_view = {mem, {XLEN{1'b0}}};
  assign run_en   = (state == RUN) && bus.clk_enable;
  assign wr_ok    = run_en && bus.write_enable && (bus.write_addr != '0) &&
                    (int'(bus.write_addr) < NUM_REGS);

  // Array contents are deliberately not reset; the clear sequence zeroes them
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      idx     <= ADDR_W'(1);
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          for (int r = 1; r < NUM_REGS; r++)
            if (idx == ADDR_W'(r)) mem[r] <= '0;
          idx <= idx + ADDR_W'(1);
          if (idx == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          for (int r = 1; r < NUM_REGS; r++)
            if (wr_ok && bus.write_addr == ADDR_W'(r)) mem[r] <= bus.write_data;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_lane
    register_file_lane #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .run_en     (run_en),
      .addr       (bus.read_addr[p*ADDR_W +: ADDR_W]),
      .wr_ok      (wr_ok),
      .write_addr (bus.write_addr),
      .write_data (bus.write_data),
      .mem_view   (mem_view),
      .rdata      (rd_lane[p])
    );
  end

  assign bus.read_data = rd_lane;
  assign bus.ready     = ready_q;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios with literal expectations plus a
// randomized run scored against an array-based reference model.
module tb_register_file;
  localparam int XLEN = 32, NR = 16, AW = 5, NRD = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  register_file_if #(.XLEN(XLEN), .ADDR_W(AW), .NUM_READ(NRD)) bus ();

  register_file #(.XLEN(XLEN), .NUM_REGS(NR), .ADDR_W(AW), .NUM_READ(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: clear modelled as a countdown of non-reset edges
  logic [31:0] ref_mem [NR];
  logic [31:0] exp_rd  [NRD];
  logic        ref_ready;
  int          clear_left;

  task automatic model_edge();
    int a, wa;
    wa = int'(bus.write_addr);
    if (rst) begin
      ref_ready  = 1'b0;
      clear_left = NR - 1;
      for (int p = 0; p < NRD; p++) exp_rd[p] = '0;
    end else if (!ref_ready) begin
      clear_left--;
      if (clear_left == 0) begin
        ref_ready = 1'b1;
        for (int r = 0; r < NR; r++) ref_mem[r] = '0;
      end
    end else if (bus.clk_enable) begin
      for (int p = 0; p < NRD; p++) begin
        a = int'(bus.read_addr[p*AW +: AW]);
        if (a == 0 || a >= NR)                          exp_rd[p] = '0;
        else if (bus.write_enable && wa == a)            exp_rd[p] = bus.write_data;
        else                                             exp_rd[p] = ref_mem[a];
      end
      if (bus.write_enable && wa != 0 && wa < NR) ref_mem[wa] = bus.write_data;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input int wa, input logic [31:0] wd,
                       input int ra0, input int ra1);
    bus.write_enable = we;
    bus.write_addr   = AW'(wa);
    bus.write_data   = wd;
    bus.read_addr    = {AW'(ra1), AW'(ra0)};
  endtask

  task automatic test_reset();
    bus.clk_enable = 1'b1;
    drive(1'b0, 0, '0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.ready !== 1'b0 || bus.read_data !== 64'h0) begin
      bad++; $display("FAIL reset_state ready=%b rd=%h want ready=0 rd=0", bus.ready, bus.read_data);
    end
    for (int i = 1; i <= 15; i++) begin
      tick();
      total++;
      if (bus.ready !== (i == 15)) begin
        bad++; $display("FAIL clear_ready edge=%0d ready=%b want %b", i, bus.ready, (i == 15));
      end
    end
    for (int r = 1; r < NR; r += 2) begin
      drive(1'b0, 0, '0, r, (r + 1) % NR);
      tick();
      total++;
      if (bus.read_data !== 64'h0) begin
        bad++; $display("FAIL clear_zero r=%0d rd=%h want 0", r, bus.read_data);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 5, 32'hDEADBEEF, 0, 0);
    tick();
    drive(1'b0, 0, '0, 5, 0);
    tick();
    total++;
    if (bus.read_data !== {32'h0, 32'hDEADBEEF}) begin
      bad++; $display("FAIL write_read rd=%h want %h", bus.read_data, {32'h0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 3, 32'h12345678, 3, 3);
    tick();
    total++;
    if (bus.read_data !== {2{32'h12345678}}) begin
      bad++; $display("FAIL bypass rd=%h want %h", bus.read_data, {2{32'h12345678}});
    end
  endtask

  task automatic test_zero_oor();
    drive(1'b1, 0, 32'hFFFFFFFF, 1, 1);
    tick();
    drive(1'b0, 0, '0, 0, 0);
    tick();
    total++;
    if (bus.read_data !== 64'h0) begin
      bad++; $display("FAIL r0_zero rd=%h want 0", bus.read_data);
    end
    // write to 17 must not alias onto r1
    drive(1'b1, 17, 32'hAAAAAAAA, 17, 1);
    tick();
    total++;
    if (bus.read_data !== 64'h0) begin
      bad++; $display("FAIL oor_same_edge rd=%h want 0", bus.read_data);
    end
    drive(1'b0, 0, '0, 17, 1);
    tick();
    total++;
    if (bus.read_data !== 64'h0) begin
      bad++; $display("FAIL oor_read rd=%h want 0", bus.read_data);
    end
  endtask

  task automatic test_stall();
    logic [63:0] held;
    drive(1'b1, 7, 32'h55, 0, 0);
    tick();
    drive(1'b0, 0, '0, 5, 0);
    tick();
    held = bus.read_data;
    bus.clk_enable = 1'b0;
    drive(1'b1, 7, 32'h66, 7, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.read_data !== held || held !== {32'h0, 32'hDEADBEEF}) begin
        bad++; $display("FAIL stall_hold edge=%0d rd=%h want %h", i, bus.read_data, {32'h0, 32'hDEADBEEF});
      end
    end
    bus.clk_enable = 1'b1;
    drive(1'b0, 0, '0, 7, 7);
    tick();
    total++;
    if (bus.read_data !== {2{32'h55}}) begin
      bad++; $display("FAIL stall_r7 rd=%h want %h", bus.read_data, {2{32'h55}});
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 0, '0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    bus.clk_enable = 1'b0;
    tick();
    rst = 1'b0;
    bus.clk_enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i >= 14) begin
        total++;
        if (bus.ready !== (i == 15)) begin
          bad++; $display("FAIL midclear_ready edge=%0d ready=%b want %b", i, bus.ready, (i == 15));
        end
      end
    end
    drive(1'b1, 2, 32'h99, 2, 0);
    tick();
    total++;
    if (bus.read_data !== {32'h0, 32'h99}) begin
      bad++; $display("FAIL r2_bypass rd=%h want %h", bus.read_data, {32'h0, 32'h99});
    end
    drive(1'b1, 4, 32'h44, 2, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 0, '0, 2, 4);
    total++;
    if (bus.ready !== 1'b0 || bus.read_data !== 64'h0) begin
      bad++; $display("FAIL run_reset ready=%b rd=%h want ready=0 rd=0", bus.ready, bus.read_data);
    end
    for (int i = 0; i < 15; i++) tick();
    tick();
    total++;
    if (bus.ready !== 1'b1 || bus.read_data !== 64'h0) begin
      bad++; $display("FAIL post_reset_r2_r4 ready=%b rd=%h want ready=1 rd=0", bus.ready, bus.read_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus.clk_enable = ($urandom_range(0, 4) != 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, NR - 1),
            ($urandom_range(0, 3) == 0) ? int'(bus.write_addr) : $urandom_range(0, NR - 1));
      if ($urandom_range(0, 2) == 0) bus.read_addr[AW +: AW] = bus.write_addr;
      tick();
      total++;
      if (bus.ready !== ref_ready || bus.read_data !== {exp_rd[1], exp_rd[0]}) begin
        bad++;
        $display("FAIL random i=%0d ready=%b rd=%h want ready=%b rd=%h",
                 i, bus.ready, bus.read_data, ref_ready, {exp_rd[1], exp_rd[0]});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ref_ready  = 1'b0;
    clear_left = NR - 1;
    for (int p = 0; p < NRD; p++) exp_rd[p] = '0;
    for (int r = 0; r < NR; r++) ref_mem[r] = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_oor();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
